// File: rtl/inv_leg_deadtime.sv
// -----------------------------------------------------------------------------
// inv_leg_deadtime
//   Gate-drive conditioner for one H-bridge leg. It synchronises the high/low
//   PWM commands and the fault-clear input. It inserts a dead time before
//   every turn-on and stretches short commands to a minimum on-time. It blocks
//   shoot-through, and it latches a fault when both commands stay high too long.
//
//   Parameters
//     DT_CYCLES      dead time in CLK_50M cycles (0 behaves as 1)
//     MIN_ON_CYCLES  minimum conduction time before a normal turn-off
//     ST_FILT        consecutive both-high cycles that latch the fault (>= 1)
//     CNT_W          counter width, holds max(DT_CYCLES, MIN_ON_CYCLES, ST_FILT)
//
//   Ports
//     CLK_50M    in   system clock
//     Rst_n      in   asynchronous active-low reset
//     PWM_H_in   in   high-side command (asynchronous)
//     PWM_L_in   in   low-side command (asynchronous)
//     En         in   leg enable, synchronous to CLK_50M (1 = run)
//     ResetD     in   fault clear (asynchronous); a rising edge clears the fault
//     PWM_H_out  out  high-side gate command
//     PWM_L_out  out  low-side gate command
//     St_fault   out  sticky shoot-through fault
//     Dt_active  out  high while dead time is being inserted
// -----------------------------------------------------------------------------
module inv_leg_deadtime #(
  parameter int DT_CYCLES     = 50,
  parameter int MIN_ON_CYCLES = 25,
  parameter int ST_FILT       = 3,
  parameter int CNT_W         = 8
) (
  input  logic CLK_50M,
  input  logic Rst_n,
  input  logic PWM_H_in,
  input  logic PWM_L_in,
  input  logic En,
  input  logic ResetD,
  output logic PWM_H_out,
  output logic PWM_L_out,
  output logic St_fault,
  output logic Dt_active
);

  typedef enum logic [2:0] {IDLE, DEAD, H_ON, L_ON, FAULT} state_t;

  // A zero dead time still gets one full cycle with both switches off.
  localparam logic [CNT_W-1:0] DT_LOAD = (DT_CYCLES == 0) ? CNT_W'(1) : CNT_W'(DT_CYCLES);
  localparam logic [CNT_W-1:0] MIN_ON  = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] ST_LIM  = CNT_W'(ST_FILT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dt_cnt, dt_nxt;
  logic [CNT_W-1:0] on_cnt, on_nxt, on_inc;
  logic [CNT_W-1:0] st_cnt, st_nxt;

  logic [1:0] h_sync, l_sync, rd_sync;
  logic       rd_prev;
  logic       req_h, req_l, req_both, req_h_only, req_l_only;
  logic       rd_rise, st_trip;

  // Two-flop synchronisers. rd_prev holds the previous synchronised ResetD
  // value for edge detection.
  // NOTE: clocked state uses non-blocking assignments so that every flop
  // samples the values from before the edge. The shift registers depend on it.
  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      h_sync  <= '0;
      l_sync  <= '0;
      rd_sync <= '0;
      rd_prev <= 1'b0;
    end else begin
      h_sync  <= {h_sync[0], PWM_H_in};
      l_sync  <= {l_sync[0], PWM_L_in};
      rd_sync <= {rd_sync[0], ResetD};
      rd_prev <= rd_sync[1];
    end
  end

  assign req_h      = h_sync[1];
  assign req_l      = l_sync[1];
  assign req_both   = req_h & req_l;
  assign req_h_only = req_h & ~req_l;
  assign req_l_only = req_l & ~req_h;
  assign rd_rise    = rd_sync[1] & ~rd_prev;

  // Count consecutive both-high cycles and saturate at the trip level.
  // The trip uses the incremented value, so the ST_FILT-th overlap cycle faults.
  always_comb begin
    st_nxt = '0;
    if (req_both) st_nxt = (st_cnt >= ST_LIM) ? st_cnt : st_cnt + ONE;
  end
  assign st_trip = req_both && (st_nxt >= ST_LIM);

  assign on_inc = (on_cnt == '1) ? on_cnt : on_cnt + ONE;

  // NOTE: every signal written here gets a default first. A path that leaves
  // one of them unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    dt_nxt    = dt_cnt;
    on_nxt    = on_cnt;
    if (state == FAULT) begin
      if (rd_rise && !req_both) begin
        state_nxt = DEAD;
        dt_nxt    = DT_LOAD;
      end
    end else if (st_trip) begin
      state_nxt = FAULT;
    end else if (!En) begin
      // Disable forces the leg off at once. Dead time stays fully loaded
      // until the leg is re-enabled.
      state_nxt = DEAD;
      dt_nxt    = DT_LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (req_h_only) begin
            state_nxt = H_ON;
            on_nxt    = ONE;
          end else if (req_l_only) begin
            state_nxt = L_ON;
            on_nxt    = ONE;
          end
        end
        H_ON: begin
          // An overlap request waives the minimum on-time. A plain release
          // must wait for it.
          if (req_both || (!req_h_only && on_cnt >= MIN_ON)) begin
            state_nxt = DEAD;
            dt_nxt    = DT_LOAD;
          end else begin
            on_nxt = on_inc;
          end
        end
        L_ON: begin
          if (req_both || (!req_l_only && on_cnt >= MIN_ON)) begin
            state_nxt = DEAD;
            dt_nxt    = DT_LOAD;
          end else begin
            on_nxt = on_inc;
          end
        end
        DEAD: begin
          if (dt_cnt <= ONE) begin
            if (req_h_only) begin
              state_nxt = H_ON;
              on_nxt    = ONE;
            end else if (req_l_only) begin
              state_nxt = L_ON;
              on_nxt    = ONE;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            dt_nxt = dt_cnt - ONE;
          end
        end
        default: begin
          state_nxt = DEAD;
          dt_nxt    = DT_LOAD;
        end
      endcase
    end
  end

  // NOTE: reset puts the leg in DEAD with a full count. The first turn-on after
  // reset then gets the same dead time as any other turn-on.
  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= DEAD;
      dt_cnt <= DT_LOAD;
      on_cnt <= '0;
      st_cnt <= '0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_nxt;
      on_cnt <= on_nxt;
      st_cnt <= st_nxt;
    end
  end

  assign PWM_H_out = (state == H_ON);
  assign PWM_L_out = (state == L_ON);
  assign St_fault  = (state == FAULT);
  assign Dt_active = (state == DEAD);

endmodule
